// File: rtl/alu4_bist.sv
// alu4_bist: exhaustive {op,a,b} self-test sequencer for a 4-bit ALU; optional response MISR via ALU4_BIST_MISR_EN
module alu4_bist #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic [1:0] op_out,
  input  logic [3:0] y_in,
  input  logic       cout_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [9:0] first_fail
`ifdef ALU4_BIST_MISR_EN
  ,
  output logic [15:0] sig
`endif
);
  localparam logic [1:0] IDLE = 2'd0, DRIVE = 2'd1, SAMPLE = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [2:0] cnt;
  logic [9:0] vec;
  logic [4:0] gold;
  logic       miss;
  // vec is both the run index and the registered operand/opcode drive
  assign {op_out, a_out, b_out} = vec;
  always_comb begin
    gold = op_out == 2'd0 ? {1'b0, a_out} + {1'b0, b_out} :
           op_out == 2'd1 ? {1'b0, a_out} - {1'b0, b_out} :
           op_out == 2'd2 ? {1'b0, a_out & b_out} : {1'b0, a_out ^ b_out};
  end
  assign miss = {cout_in, y_in} != gold;
  assign busy = state == DRIVE || state == SAMPLE;
  assign done = state == DONE;
  assign pass = done && err_count == 8'd0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      vec        <= '0;
      err_count  <= '0;
      first_fail <= '0;
`ifdef ALU4_BIST_MISR_EN
      sig        <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state      <= DRIVE;
          cnt        <= '0;
          vec        <= '0;
          err_count  <= '0;
          first_fail <= '0;
`ifdef ALU4_BIST_MISR_EN
          sig        <= 16'hffff;
`endif
        end
        DRIVE: begin
          if (cnt == 3'(SETTLE_CYCLES - 1)) state <= SAMPLE;
          else cnt <= cnt + 3'd1;
        end
        default: begin
          if (miss) begin
            err_count <= err_count + {7'd0, err_count != 8'hff};
            if (err_count == 8'd0) first_fail <= vec;
          end
`ifdef ALU4_BIST_MISR_EN
          sig <= {sig[14:0], 1'b0} ^ {3'd0, sig[15], 6'd0, sig[15], 4'd0, sig[15]} ^ {11'd0, cout_in, y_in};
`endif
          state <= vec == 10'h3ff ? DONE : DRIVE;
          vec   <= vec == 10'h3ff ? 10'd0 : vec + 10'd1;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu4_bist.sv
// tb_alu4_bist: directed runs against a modelled ALU with injectable faults, scoreboarded run results
module tb_alu4_bist;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] a_out, b_out, y_in;
  logic [1:0] op_out;
  logic       cout_in, busy, done, pass;
  logic [7:0] err_count;
  logic [9:0] first_fail;
  logic [15:0] sig;
  int mode = 0, ncmp = 0, nerr = 0;
  typedef struct {
    int         edges;
    logic       pass;
    logic [7:0] err;
    logic [9:0] ff;
    logic [15:0] sig;
  } exp_t;
  exp_t sb[$];
  logic [15:0] good_sig;
  alu4_bist dut (
    .clk(clk), .rst(rst), .start(start), .a_out(a_out), .b_out(b_out), .op_out(op_out),
    .y_in(y_in), .cout_in(cout_in), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail)
`ifdef ALU4_BIST_MISR_EN
    , .sig(sig)
`endif
  );
`ifndef ALU4_BIST_MISR_EN
  assign sig = 16'd0;
`endif
  always #5 clk = ~clk;
  function automatic int respond(input int op, input int a, input int b, input int f);
    int r;
    case (op)
      0: r = a + b;
      1: r = (a - b) & 31;
      2: r = a & b;
      default: r = a ^ b;
    endcase
    if (f == 1) r = r & ~1;
    if (f == 2) r = r | 16;
    return r;
  endfunction
  always_comb begin
    {cout_in, y_in} = 5'(respond(int'(op_out), int'(a_out), int'(b_out), mode));
  end
  function automatic exp_t model(input int f);
    exp_t e;
    int r, g, cnt;
    logic [15:0] s;
    cnt = 0; s = 16'hffff;
    e.ff = '0;
    for (int v = 0; v < 1024; v++) begin
      g = respond(v / 256, (v / 16) % 16, v % 16, 0);
      r = respond(v / 256, (v / 16) % 16, v % 16, f);
      if (r != g) begin
        if (cnt == 0) e.ff = 10'(v);
        if (cnt < 255) cnt++;
      end
      s = (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000) ^ 16'(r);
    end
    e.edges = 2048; e.err = 8'(cnt); e.pass = cnt == 0; e.sig = s;
    return e;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input int f, input int inj);
    exp_t e;
    int edges;
    bit injected;
    sb.push_back(model(f));
    mode = f;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_clear_on_start", err_count, 0);
    chk("ff_clear_on_start", first_fail, 0);
    edges = 0; injected = 0;
    while (!done && edges < 3000) begin
      if (inj >= 0 && !injected && {op_out, a_out, b_out} == 10'(inj)) begin
        start = 1'b1;
        injected = 1;
      end
      @(posedge clk) #1 start = 1'b0;
      edges++;
    end
    e = sb.pop_front();
    chk("done_edges", edges, e.edges);
    chk("done", done, 1);
    chk("busy_in_done", busy, 0);
    chk("pass", pass, e.pass);
    chk("err_count", err_count, e.err);
    chk("first_fail", first_fail, e.ff);
    chk("vec_zero_in_done", {op_out, a_out, b_out}, 0);
`ifdef ALU4_BIST_MISR_EN
    chk("sig", sig, e.sig);
    if (f != 0) begin
      ncmp++;
      assert (sig !== good_sig) else begin
        nerr++;
        $error("FAIL sig_fault_visible observed=%0h expected!=%0h", sig, good_sig);
      end
    end
`endif
  endtask
  initial begin
    good_sig = model(0).sig;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ff", first_fail, 0);
    chk("rst_vec", {op_out, a_out, b_out}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("idle_no_start", busy, 0);
    run(0, 10);
    run(1, -1);
    run(0, -1);
    run(2, -1);
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    for (int i = 0; i < 3000 && {op_out, a_out, b_out} != 10'd300; i++) @(posedge clk) #1;
    chk("reached_300", {op_out, a_out, b_out}, 300);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_pass", pass, 0);
    chk("midrst_err", err_count, 0);
    chk("midrst_ff", first_fail, 0);
    chk("midrst_vec", {op_out, a_out, b_out}, 0);
`ifdef ALU4_BIST_MISR_EN
    chk("midrst_sig", sig, 0);
`endif
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("no_resume_busy", busy, 0);
    chk("no_resume_vec", {op_out, a_out, b_out}, 0);
    run(0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
